zoom_scan_controller: RTL and testbench



---
 rtl/zoom_scan_controller.sv | 147 ++++++++++++++
 tb/tb_zoom_scan_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_scan_controller.sv
// 2x pixel-replication zoom sequencer: walks the enlarged frame in raster order, reads the source
// image and writes the output frame buffer. Optional FRAME_CNT port under `FRAME_COUNT_EN.
module zoom_scan_controller #(
  parameter int unsigned IMG_WIDTH_IN  = 160,
  parameter int unsigned IMG_HEIGHT_IN = 120,
  parameter int unsigned SHIFT_FACTOR  = 1,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic [14:0] R_ADDR,
  input  logic [7:0]  R_DATA,
  output logic [16:0] W_ADDR,
  output logic [7:0]  W_DATA,
  output logic        W_EN,
  output logic        BUSY,
  output logic        DONE
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0] FRAME_CNT
`endif
);

  localparam int unsigned OUT_W = IMG_WIDTH_IN << SHIFT_FACTOR;
  localparam int unsigned OUT_H = IMG_HEIGHT_IN << SHIFT_FACTOR;
  localparam int unsigned XW    = $clog2(OUT_W);
  localparam int unsigned YW    = $clog2(OUT_H);
  localparam int unsigned DW    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [XW-1:0] XMax    = XW'(OUT_W - 1);
  localparam logic [YW-1:0] YMax    = YW'(OUT_H - 1);
  localparam logic [DW-1:0] DrainMax = DW'(RD_LATENCY - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StScan   = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [14:0]   r_addr_q, r_addr_d;
  logic [7:0]    data_q;

  // Stage 0 is aligned with R_ADDR; stage RD_LATENCY is aligned with the returning R_DATA.
  logic          vld_q [RD_LATENCY+1];
  logic [16:0]   wa_q  [RD_LATENCY+1];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StScan;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StScan: begin
        if (x_q == XMax) begin
          x_d = '0;
          if (y_q == YMax) begin
            state_d = StDrain;
            drain_d = '0;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DrainMax) begin
          state_d = StFinish;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Source address of the coordinate that will be current in the next SCAN cycle.
  assign r_addr_d = 15'(((32'(y_d) >> SHIFT_FACTOR) * IMG_WIDTH_IN) + (32'(x_d) >> SHIFT_FACTOR));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      drain_q  <= '0;
      r_addr_q <= '0;
      data_q   <= '0;
      for (int i = 0; i <= int'(RD_LATENCY); i++) begin
        vld_q[i] <= 1'b0;
        wa_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      if (state_d == StScan) begin
        r_addr_q <= r_addr_d;
        wa_q[0]  <= (state_q == StScan) ? wa_q[0] + 17'd1 : '0;
      end
      vld_q[0] <= (state_d == StScan);
      for (int i = 1; i <= int'(RD_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          wa_q[i] <= wa_q[i-1];
        end
      end
      if (vld_q[RD_LATENCY]) begin
        data_q <= R_DATA;
      end
    end
  end

  assign R_ADDR = r_addr_q;
  assign W_EN   = vld_q[RD_LATENCY];
  assign W_ADDR = wa_q[RD_LATENCY];
  assign W_DATA = W_EN ? R_DATA : data_q;
  assign BUSY   = (state_q == StScan) || (state_q == StDrain);
  assign DONE   = (state_q == StFinish);

`ifdef FRAME_COUNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_q <= '0;
    end else if (state_q == StFinish) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign FRAME_CNT = frame_q;
`endif

endmodule

// File: tb/tb_zoom_scan_controller.sv
// Bench for zoom_scan_controller: two full-size instances (latency 1 and 3) plus two reduced-size
// instances (latency 2 and 4) for reset-abort and back-to-back pass scenarios.
module tb_zoom_scan_controller;

  logic        clk = 1'b0;
  logic        rst   [4];
  logic        start [4];
  logic [14:0] r_addr [4];
  logic [7:0]  r_data [4];
  logic [16:0] w_addr [4];
  logic [7:0]  w_data [4];
  logic        w_en   [4];
  logic        busy   [4];
  logic        done   [4];
`ifdef FRAME_COUNT_EN
  logic [15:0] frame_cnt [4];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned WIN = (g < 2) ? 160 : 16;
    localparam int unsigned HIN = (g < 2) ? 120 : 12;
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
    logic [7:0] pipe [4];

    zoom_scan_controller #(
      .IMG_WIDTH_IN (WIN),
      .IMG_HEIGHT_IN(HIN),
      .SHIFT_FACTOR (1),
      .RD_LATENCY   (LAT)
    ) u_dut (
      .CLK   (clk),
      .RESET (rst[g]),
      .START (start[g]),
      .R_ADDR(r_addr[g]),
      .R_DATA(r_data[g]),
      .W_ADDR(w_addr[g]),
      .W_DATA(w_data[g]),
      .W_EN  (w_en[g]),
      .BUSY  (busy[g]),
      .DONE  (done[g])
`ifdef FRAME_COUNT_EN
      ,
      .FRAME_CNT(frame_cnt[g])
`endif
    );

    // Source memory: returns address[7:0] LAT cycles after the address.
    always @(posedge clk) begin
      pipe[0] <= r_addr[g][7:0];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign r_data[g] = pipe[LAT-1];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cyc [4], busy_idx [4], wr_cnt [4], exp_wa [4], done_cnt [4];
  int ord_err [4], dat_err [4], radr_err [4], lat_err [4], done_err [4], gap_err [4];
  int last_wr_t [4], last_done_t [4];
  logic [14:0] ra_first [5];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : (d == 2) ? 2 : 4;
  endfunction

  function automatic int in_w(input int d);
    return (d < 2) ? 160 : 16;
  endfunction

  function automatic int npix(input int d);
    return (d < 2) ? 76800 : 768;
  endfunction

  function automatic logic [31:0] exp_r(input int d, input int k);
    int x, y;
    x = k % (2 * in_w(d));
    y = k / (2 * in_w(d));
    return 32'((y >> 1) * in_w(d) + (x >> 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear(input int d);
    busy_cyc[d] = 0; busy_idx[d] = 0; wr_cnt[d] = 0; exp_wa[d] = 0; done_cnt[d] = 0;
    ord_err[d] = 0; dat_err[d] = 0; radr_err[d] = 0; lat_err[d] = 0; done_err[d] = 0;
    gap_err[d] = 0; last_wr_t[d] = -10; last_done_t[d] = -10;
  endtask

  // One clock: sample every instance at the falling edge and update its scoreboard.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 4; d++) begin
      if (w_en[d] === 1'b1) begin
        wr_cnt[d]++;
        if (int'(w_addr[d]) != exp_wa[d] || busy[d] !== 1'b1) ord_err[d]++;
        e = exp_r(d, int'(w_addr[d]));
        if (w_data[d] !== e[7:0]) dat_err[d]++;
        if (busy_idx[d] != int'(w_addr[d]) + lat(d)) lat_err[d]++;
        last_wr_t[d] = cyc;
        exp_wa[d] = (exp_wa[d] == npix(d) - 1) ? 0 : exp_wa[d] + 1;
      end
      if (busy[d] === 1'b1) begin
        if (busy_idx[d] == 0 && done_cnt[d] > 0 && cyc - last_done_t[d] != 2) gap_err[d]++;
        if (busy_idx[d] < npix(d)) begin
          e = exp_r(d, busy_idx[d]);
          if (r_addr[d] !== e[14:0]) radr_err[d]++;
          if (d == 0 && busy_idx[d] < 5) ra_first[busy_idx[d]] = r_addr[d];
        end
        busy_idx[d]++;
        busy_cyc[d]++;
      end else begin
        busy_idx[d] = 0;
      end
      if (done[d] === 1'b1) begin
        done_cnt[d]++;
        if (cyc != last_wr_t[d] + 1 || busy[d] !== 1'b0) done_err[d]++;
        last_done_t[d] = cyc;
      end
    end
  endtask

  task automatic check_pass(input int d, input int passes);
    check($sformatf("d%0d_done_cnt", d), done_cnt[d], passes);
    check($sformatf("d%0d_wr_cnt", d), wr_cnt[d], passes * npix(d));
    check($sformatf("d%0d_busy_cycles", d), busy_cyc[d], passes * (npix(d) + lat(d)));
    check($sformatf("d%0d_waddr_order_err", d), ord_err[d], 0);
    check($sformatf("d%0d_wdata_err", d), dat_err[d], 0);
    check($sformatf("d%0d_raddr_err", d), radr_err[d], 0);
    check($sformatf("d%0d_latency_err", d), lat_err[d], 0);
    check($sformatf("d%0d_done_timing_err", d), done_err[d], 0);
    check($sformatf("d%0d_gap_err", d), gap_err[d], 0);
  endtask

  task automatic check_frame(input int d, input int n);
`ifdef FRAME_COUNT_EN
    check($sformatf("d%0d_frame_cnt", d), frame_cnt[d], n);
`else
    if (d < 0 || n < 0) $display("unused");
`endif
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1;
      start[d] = 1'b0;
      clear(d);
    end
    repeat (3) tick();
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;
    tick();

    // Reset state
    for (int d = 0; d < 4; d++) begin
      check($sformatf("d%0d_rst_r_addr", d), r_addr[d], 0);
      check($sformatf("d%0d_rst_w_addr", d), w_addr[d], 0);
      check($sformatf("d%0d_rst_w_data", d), w_data[d], 0);
      check($sformatf("d%0d_rst_w_en", d), w_en[d], 0);
      check($sformatf("d%0d_rst_busy", d), busy[d], 0);
      check($sformatf("d%0d_rst_done", d), done[d], 0);
      check_frame(d, 0);
      clear(d);
    end

    // Full-size passes: d0 single START, d1 with START re-pulsed during the pass
    for (int i = 0; i < 76820; i++) begin
      start[0] = (i == 0);
      start[1] = (i == 0) || (i % 1000 == 500);
      tick();
    end
    start[0] = 1'b0;
    start[1] = 1'b0;
    check("d0_raddr_0", ra_first[0], 0);
    check("d0_raddr_1", ra_first[1], 0);
    check("d0_raddr_2", ra_first[2], 1);
    check("d0_raddr_3", ra_first[3], 1);
    check("d0_raddr_4", ra_first[4], 2);
    check_pass(0, 1);
    check_pass(1, 1);
    check_frame(0, 1);
    check_frame(1, 1);

    // d2: full reduced pass, then a pass aborted by reset, then a clean pass
    clear(2);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    repeat (800) tick();
    check_pass(2, 1);
    check_frame(2, 1);

    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    repeat (300) tick();
    check("d2_wen_before_abort", w_en[2], 1);
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    check("d2_abort_w_en", w_en[2], 0);
    check("d2_abort_busy", busy[2], 0);
    check("d2_abort_done", done[2], 0);
    check("d2_abort_r_addr", r_addr[2], 0);
    check("d2_abort_w_addr", w_addr[2], 0);
    check_frame(2, 0);
    clear(2);
    repeat (20) tick();
    check("d2_abort_no_done", done_cnt[2], 0);
    check("d2_abort_no_write", wr_cnt[2], 0);
    clear(2);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    repeat (800) tick();
    check_pass(2, 1);
    check_frame(2, 1);

    // d3: START held high across two passes
    clear(3);
    start[3] = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (done[3] === 1'b1 && done_cnt[3] == 2) begin
        start[3] = 1'b0;
        break;
      end
    end
    start[3] = 1'b0;
    repeat (20) tick();
    check_pass(3, 2);
    check_frame(3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
